periph_rr_arbiter: RTL and testbench
====================================

// Module: periph_rr_arbiter
// PURPOSE
//  Upstream control stage for the Peripheral_Unit 4:1 data mux. Arbitrates four
//  peripheral requesters round-robin, drives the mux select, captures the selected
//  mux output into a holding register, and presents it downstream on a valid/ready
//  handshake. Per-source grant pulses tell each peripheral its word was consumed.
// PARAMETERS
//  WIDTH     32   data width; must match the WIDTH of the downstream mux instance
// PORTS
//  CLK        in   1      system clock; all state updates on rising edge
//  RST        in   1      synchronous, active-high reset
//  REQ        in   4      per-source request; bit i = source i has a word on mux input i
//  EN         in   4      per-source enable mask; a source with EN[i]=0 is never picked
//  SEL        out  2      select to mux; index of the source being serviced
//  MUX_DATA   in   WIDTH  mux output, combinationally dependent on SEL
//  GNT        out  4      one-hot, one-cycle pulse: source i's word was captured
//  OUT_DATA   out  WIDTH  captured word
//  OUT_SRC    out  2      source index of OUT_DATA
//  OUT_VALID  out  1      OUT_DATA/OUT_SRC valid
//  OUT_READY  in   1      downstream accepts when OUT_VALID & OUT_READY
// BEHAVIOUR
//  Reset (RST=1 at edge): state=IDLE, SEL=0, GNT=0, OUT_DATA=0, OUT_SRC=0,
//   OUT_VALID=0, LAST=3 (so source 0 has top priority first). RST overrides all;
//   a word in flight or unaccepted is dropped, no GNT issued.
//  Eligible set E = REQ & EN.
//  FSM: IDLE -> SELECT -> HOLD -> IDLE.
//  IDLE: if E!=0, pick first set bit of E searching LAST+1, LAST+2, ... mod 4
//   (wrap 3->0). Register SEL=pick, LAST=pick; go SELECT. If E==0 stay IDLE,
//   SEL holds previous value.
//  SELECT (1 cycle, lets mux settle): at edge, OUT_DATA<=MUX_DATA, OUT_SRC<=SEL,
//   OUT_VALID<=1, GNT<=onehot(SEL) for exactly one cycle; go HOLD. Capture happens
//   even if REQ[SEL] dropped during SELECT (sources must hold REQ until GNT).
//  HOLD: OUT_DATA/OUT_SRC/OUT_VALID stable while OUT_VALID & ~OUT_READY.
//   On edge with OUT_READY=1: OUT_VALID<=0, go IDLE.
//  Latency: REQ seen in IDLE at edge N -> SEL at N+1 -> OUT_VALID and GNT at N+2.
//  Throughput: max one word per 3 cycles (IDLE, SELECT, HOLD w/ READY=1).
//  SEL changes only on IDLE->SELECT; constant through SELECT and HOLD.
//  GNT is zero in all cycles except the one after the SELECT edge; never >1 bit.
//  EN changes take effect at the next IDLE decision only.
//  Fairness: with all four continuously eligible, service order 0,1,2,3,0,...;
//   any continuously eligible source is serviced within 4 grants.
//  OUT_READY ignored when OUT_VALID=0.
// TESTING
//  1 Reset: RST=1 2 cyc, REQ=4'hF -> all outputs 0, first grant after release is src 0.
//  2 Single: REQ=4'b0100, MUX_DATA=32'hDEADBEEF, READY=1 -> SEL=2 at N+1, GNT=4'b0100,
//    OUT_VALID, OUT_DATA=32'hDEADBEEF, OUT_SRC=2 at N+2.
//  3 Round-robin: REQ=4'hF held, READY=1 -> OUT_SRC sequence 0,1,2,3,0,1; one word/3 cyc.
//  4 Backpressure: READY=0 for 5 cyc after OUT_VALID -> OUT_DATA/SRC/SEL stable, no new
//    GNT; READY=1 -> OUT_VALID drops next cycle, next arbitration follows.
//  5 Mask/wrap: LAST=3, REQ=4'b1001, EN=4'b1000 -> picks src 3 (src 0 masked).
//  6 Reset mid-op: RST asserted in SELECT -> no GNT, OUT_VALID=0, LAST=3 next cycle.

Source files
------------

// File: rtl/periph_rr_arbiter_if.sv
// Bus bundle between the round-robin arbiter, the peripheral mux and the
// downstream consumer.
interface periph_rr_arbiter_if #(
    parameter int WIDTH = 32
) ();
    logic [3:0]       REQ;
    logic [3:0]       EN;
    logic [1:0]       SEL;
    logic [WIDTH-1:0] MUX_DATA;
    logic [3:0]       GNT;
    logic [WIDTH-1:0] OUT_DATA;
    logic [1:0]       OUT_SRC;
    logic             OUT_VALID;
    logic             OUT_READY;

    modport master (
        input  REQ, EN, MUX_DATA, OUT_READY,
        output SEL, GNT, OUT_DATA, OUT_SRC, OUT_VALID
    );

    modport slave (
        output REQ, EN, MUX_DATA, OUT_READY,
        input  SEL, GNT, OUT_DATA, OUT_SRC, OUT_VALID
    );
endinterface

// File: rtl/periph_rr_arbiter.sv
// Round-robin arbiter over four peripheral sources: drives the mux select,
// captures the muxed word and hands it downstream on valid/ready.
module periph_rr_arbiter #(
    parameter int WIDTH = 32
) (
    input logic                CLK,
    input logic                RST,
    periph_rr_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;

    logic [3:0] elig;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;

    assign elig = bus.REQ & bus.EN;

    // Search starts one past the last winner, wrapping 3 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        gnt_d       = '0;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    last_d  = pick;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                out_data_d  = bus.MUX_DATA;
                out_src_d   = sel_q;
                out_valid_d = 1'b1;
                gnt_d       = 4'b0001 << sel_q;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.OUT_READY) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            last_q      <= 2'd3;
            gnt_q       <= '0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.SEL       = sel_q;
    assign bus.GNT       = gnt_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_SRC   = out_src_q;
    assign bus.OUT_VALID = out_valid_q;
endmodule

// File: tb/tb_periph_rr_arbiter.sv
// Directed bench for periph_rr_arbiter: reset, single word, round-robin,
// backpressure, mask/wrap and reset in the middle of a transfer.
module tb_periph_rr_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [31:0] words [4];

    periph_rr_arbiter_if #(.WIDTH(32)) bus ();

    periph_rr_arbiter #(.WIDTH(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    // Behavioural 4:1 mux sitting downstream of SEL.
    assign bus.MUX_DATA = words[bus.SEL];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST           = 1'b1;
        bus.REQ       = 4'h0;
        bus.EN        = 4'hF;
        bus.OUT_READY = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST           = 1'b1;
        bus.REQ       = 4'hF;
        bus.EN        = 4'hF;
        bus.OUT_READY = 1'b1;
        tick();
        tick();
        tot_cnt++;
        if (bus.SEL !== 2'd0) $display("FAIL reset_sel got %0d want 0", bus.SEL);
        else pass_cnt++;
        tot_cnt++;
        if (bus.GNT !== 4'h0) $display("FAIL reset_gnt got %b want 0000", bus.GNT);
        else pass_cnt++;
        tot_cnt++;
        if (bus.OUT_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.OUT_VALID);
        else pass_cnt++;
        tot_cnt++;
        if (bus.OUT_DATA !== 32'h0) $display("FAIL reset_data got %h want 0", bus.OUT_DATA);
        else pass_cnt++;
        tot_cnt++;
        if (bus.OUT_SRC !== 2'd0) $display("FAIL reset_src got %0d want 0", bus.OUT_SRC);
        else pass_cnt++;
        RST = 1'b0;
        tick();
        tick();
        tot_cnt++;
        if (bus.GNT !== 4'b0001) $display("FAIL reset_first_gnt got %b want 0001", bus.GNT);
        else pass_cnt++;
        tot_cnt++;
        if (bus.OUT_SRC !== 2'd0) $display("FAIL reset_first_src got %0d want 0", bus.OUT_SRC);
        else pass_cnt++;
        tot_cnt++;
        if (bus.OUT_DATA !== 32'hA000_0000) $display("FAIL reset_first_data got %h want a0000000", bus.OUT_DATA);
        else pass_cnt++;
        bus.REQ = 4'h0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        words[2] = 32'hDEAD_BEEF;
        bus.REQ  = 4'b0100;
        tick();
        tot_cnt++;
        if (bus.SEL !== 2'd2) $display("FAIL single_sel got %0d want 2", bus.SEL);
        else pass_cnt++;
        tot_cnt++;
        if (bus.OUT_VALID !== 1'b0) $display("FAIL single_early_valid got %b want 0", bus.OUT_VALID);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (bus.GNT !== 4'b0100) $display("FAIL single_gnt got %b want 0100", bus.GNT);
        else pass_cnt++;
        tot_cnt++;
        if (bus.OUT_VALID !== 1'b1) $display("FAIL single_valid got %b want 1", bus.OUT_VALID);
        else pass_cnt++;
        tot_cnt++;
        if (bus.OUT_DATA !== 32'hDEAD_BEEF) $display("FAIL single_data got %h want deadbeef", bus.OUT_DATA);
        else pass_cnt++;
        tot_cnt++;
        if (bus.OUT_SRC !== 2'd2) $display("FAIL single_src got %0d want 2", bus.OUT_SRC);
        else pass_cnt++;
        bus.REQ = 4'h0;
        tick();
        tot_cnt++;
        if (bus.OUT_VALID !== 1'b0 || bus.GNT !== 4'h0)
            $display("FAIL single_drop valid=%b gnt=%b want 0/0000", bus.OUT_VALID, bus.GNT);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (bus.SEL !== 2'd2) $display("FAIL single_sel_hold got %0d want 2", bus.SEL);
        else pass_cnt++;
        words[2] = 32'hA000_0002;
    endtask

    task automatic test_round_robin();
        logic [1:0] order [6];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        bus.REQ = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            tot_cnt++;
            if (bus.OUT_VALID !== 1'b0)
                $display("FAIL rr_gap%0d valid got %b want 0", i, bus.OUT_VALID);
            else pass_cnt++;
            tick();
            tot_cnt++;
            if (bus.OUT_SRC !== order[i])
                $display("FAIL rr_src%0d got %0d want %0d", i, bus.OUT_SRC, order[i]);
            else pass_cnt++;
            tot_cnt++;
            if (bus.GNT !== (4'b0001 << order[i]) || bus.OUT_VALID !== 1'b1)
                $display("FAIL rr_gnt%0d got %b/%b want %b/1", i, bus.GNT, bus.OUT_VALID, 4'b0001 << order[i]);
            else pass_cnt++;
            tot_cnt++;
            if (bus.OUT_DATA !== (32'hA000_0000 | 32'(order[i])))
                $display("FAIL rr_data%0d got %h want %h", i, bus.OUT_DATA, 32'hA000_0000 | 32'(order[i]));
            else pass_cnt++;
            tick();
        end
        bus.REQ = 4'h0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.OUT_READY = 1'b0;
        bus.REQ       = 4'b0010;
        tick();
        tick();
        tot_cnt++;
        if (bus.GNT !== 4'b0010 || bus.OUT_SRC !== 2'd1)
            $display("FAIL bp_first gnt=%b src=%0d want 0010/1", bus.GNT, bus.OUT_SRC);
        else pass_cnt++;
        bus.REQ = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            tot_cnt++;
            if (bus.OUT_VALID !== 1'b1 || bus.GNT !== 4'h0 || bus.SEL !== 2'd1 ||
                bus.OUT_SRC !== 2'd1 || bus.OUT_DATA !== 32'hA000_0001)
                $display("FAIL bp_stall%0d v=%b g=%b sel=%0d src=%0d d=%h want 1/0000/1/1/a0000001",
                         i, bus.OUT_VALID, bus.GNT, bus.SEL, bus.OUT_SRC, bus.OUT_DATA);
            else pass_cnt++;
        end
        bus.OUT_READY = 1'b1;
        tick();
        tot_cnt++;
        if (bus.OUT_VALID !== 1'b0) $display("FAIL bp_release valid got %b want 0", bus.OUT_VALID);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (bus.SEL !== 2'd2) $display("FAIL bp_next_sel got %0d want 2", bus.SEL);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (bus.GNT !== 4'b0100 || bus.OUT_SRC !== 2'd2)
            $display("FAIL bp_next gnt=%b src=%0d want 0100/2", bus.GNT, bus.OUT_SRC);
        else pass_cnt++;
        bus.REQ = 4'h0;
        tick();
    endtask

    task automatic test_mask_wrap();
        do_reset();
        bus.REQ = 4'b1001;
        bus.EN  = 4'b1000;
        tick();
        tot_cnt++;
        if (bus.SEL !== 2'd3) $display("FAIL mask_sel got %0d want 3", bus.SEL);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (bus.GNT !== 4'b1000 || bus.OUT_SRC !== 2'd3)
            $display("FAIL mask_gnt gnt=%b src=%0d want 1000/3", bus.GNT, bus.OUT_SRC);
        else pass_cnt++;
        bus.EN = 4'hF;
        tick();
        tick();
        tot_cnt++;
        if (bus.SEL !== 2'd0) $display("FAIL wrap_sel got %0d want 0", bus.SEL);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (bus.GNT !== 4'b0001) $display("FAIL wrap_gnt got %b want 0001", bus.GNT);
        else pass_cnt++;
        tick();
        tick();
        tot_cnt++;
        if (bus.SEL !== 2'd3) $display("FAIL skip_sel got %0d want 3", bus.SEL);
        else pass_cnt++;
        bus.REQ = 4'h0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        bus.REQ = 4'hF;
        tick();
        tot_cnt++;
        if (bus.SEL !== 2'd0) $display("FAIL mid_sel got %0d want 0", bus.SEL);
        else pass_cnt++;
        RST = 1'b1;
        tick();
        tot_cnt++;
        if (bus.GNT !== 4'h0 || bus.OUT_VALID !== 1'b0)
            $display("FAIL mid_abort gnt=%b valid=%b want 0000/0", bus.GNT, bus.OUT_VALID);
        else pass_cnt++;
        RST = 1'b0;
        tick();
        tot_cnt++;
        if (bus.SEL !== 2'd0) $display("FAIL mid_last sel got %0d want 0", bus.SEL);
        else pass_cnt++;
        tick();
        tot_cnt++;
        if (bus.GNT !== 4'b0001 || bus.OUT_VALID !== 1'b1)
            $display("FAIL mid_regrant gnt=%b valid=%b want 0001/1", bus.GNT, bus.OUT_VALID);
        else pass_cnt++;
        bus.REQ = 4'h0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) words[i] = 32'hA000_0000 | 32'(i);
        bus.REQ       = 4'h0;
        bus.EN        = 4'hF;
        bus.OUT_READY = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_mask_wrap();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
